// File: rtl/scarv_soc_bram_pkg.sv
// Shared BRAM helpers: lane geometry, address-width derivation and legal data widths.
// Used by both the single-port and the dual-port BRAM.
package scarv_soc_bram_pkg;

    localparam int BRAM_DW_LEGAL_A = 32;
    localparam int BRAM_DW_LEGAL_B = 64;

    function automatic int bram_lanes(input int dw);
        return dw / 8;
    endfunction

    function automatic int bram_lane_shift(input int dw);
        return $clog2(dw / 8);
    endfunction

    function automatic int bram_lw(input int depth);
        return $clog2(depth);
    endfunction

    function automatic bit bram_dw_legal(input int dw);
        return (dw == BRAM_DW_LEGAL_A) || (dw == BRAM_DW_LEGAL_B);
    endfunction

    function automatic bit bram_is_pow2(input int n);
        return (n > 0) && ((n & (n - 1)) == 0);
    endfunction

endpackage

// File: rtl/scarv_soc_bram_rdpipe.sv
// Per-port read pipeline: STAGES registers of data plus a matching valid shift register.
// Data in a stage only advances when its upstream slot is valid, so dout holds across idle cycles.
module scarv_soc_bram_rdpipe
    import scarv_soc_bram_pkg::*;
#(
    parameter int DW     = 32,
    parameter int STAGES = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic [DW-1:0] rdata,
    output logic [DW-1:0] dout,
    output logic          valid
);

    logic [STAGES-1:0]         vld_pipe;
    logic [STAGES-1:0][DW-1:0] dat_pipe;

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_pipe <= '0;
            dat_pipe <= '0;
        end else begin
            vld_pipe <= STAGES'({vld_pipe, en});
            if (en) dat_pipe[0] <= rdata;
            for (int s = 1; s < STAGES; s++) begin
                if (vld_pipe[s-1]) dat_pipe[s] <= dat_pipe[s-1];
            end
        end
    end

    assign dout  = dat_pipe[STAGES-1];
    assign valid = vld_pipe[STAGES-1];

endmodule

// File: rtl/scarv_soc_bram_dual.sv
// True dual-port byte-addressed BRAM, read-first on both ports, port A wins write collisions.
// Define SCARV_SOC_BRAM_DUAL_OUTREG_EN for an extra output register stage (read latency 2).
module scarv_soc_bram_dual
    import scarv_soc_bram_pkg::*;
#(
    parameter int    DEPTH     = 4096,
    parameter int    DW        = 32,
    parameter int    AW        = 14,
    parameter string MEMH_FILE = ""
) (
    input  logic            clka,
    input  logic            rsta,
    input  logic            ena,
    input  logic [DW/8-1:0] wea,
    input  logic [AW-1:0]   addra,
    input  logic [DW-1:0]   dina,
    output logic [DW-1:0]   douta,
    output logic            valida,
    input  logic            enb,
    input  logic [DW/8-1:0] web,
    input  logic [AW-1:0]   addrb,
    input  logic [DW-1:0]   dinb,
    output logic [DW-1:0]   doutb,
    output logic            validb
);

    localparam int NL = bram_lanes(DW);
    localparam int LW = bram_lw(DEPTH);
`ifdef SCARV_SOC_BRAM_DUAL_OUTREG_EN
    localparam int RD_STAGES = 2;
`else
    localparam int RD_STAGES = 1;
`endif

    if (!bram_is_pow2(DEPTH)) begin : g_bad_depth
        $error("scarv_soc_bram_dual: DEPTH must be a power of two");
    end
    if (!bram_dw_legal(DW)) begin : g_bad_dw
        $error("scarv_soc_bram_dual: DW must be 32 or 64");
    end
    if (DEPTH < NL) begin : g_bad_small
        $error("scarv_soc_bram_dual: DEPTH must hold at least one word");
    end
    if (AW < LW) begin : g_bad_aw
        $error("scarv_soc_bram_dual: AW too narrow for DEPTH");
    end

    logic [7:0] mem [DEPTH];

    // Upper address bits fall away (wrap modulo DEPTH); lane bits are masked off.
    logic [LW-1:0] base_a, base_b;
    logic          unused_addr;
    assign base_a      = addra[LW-1:0] & ~LW'(NL - 1);
    assign base_b      = addrb[LW-1:0] & ~LW'(NL - 1);
    assign unused_addr = ^{addra, addrb};

    logic [DW-1:0] rdata_a, rdata_b;

    always_comb begin
        rdata_a = '0;
        rdata_b = '0;
        for (int i = 0; i < NL; i++) begin
            rdata_a[8*i +: 8] = mem[base_a | LW'(i)];
            rdata_b[8*i +: 8] = mem[base_b | LW'(i)];
        end
    end

    // Port B is applied first so a colliding port A lane overrides it.
    always_ff @(posedge clka) begin
        if (!rsta) begin
            for (int i = 0; i < NL; i++) begin
                if (enb && web[i]) mem[base_b | LW'(i)] <= dinb[8*i +: 8];
            end
            for (int i = 0; i < NL; i++) begin
                if (ena && wea[i]) mem[base_a | LW'(i)] <= dina[8*i +: 8];
            end
        end
    end

    scarv_soc_bram_rdpipe #(.DW(DW), .STAGES(RD_STAGES)) u_rdpipe_a (
        .clk   (clka),
        .rst   (rsta),
        .en    (ena),
        .rdata (rdata_a),
        .dout  (douta),
        .valid (valida)
    );

    scarv_soc_bram_rdpipe #(.DW(DW), .STAGES(RD_STAGES)) u_rdpipe_b (
        .clk   (clka),
        .rst   (rsta),
        .en    (enb),
        .rdata (rdata_b),
        .dout  (doutb),
        .valid (validb)
    );

endmodule
